maze_player_ctrl: RTL and testbench
===================================

MAZE_PLAYER_CTRL -- requirements
Module: maze_player_ctrl

Interface
REQ-001 SHALL have parameter GRID_W, default 16: maze storage columns.
REQ-002 SHALL have parameter GRID_H, default 16: maze storage rows.
REQ-003 SHALL have parameter XW, default 4: x-coordinate width, where 2**XW >= GRID_W.
REQ-004 SHALL have parameter YW, default 4: y-coordinate width, where 2**YW >= GRID_H.
REQ-005 SHALL have parameter STEP_CYCLES, default 5_000_000: auto-repeat interval in clk cycles; must be >= 2.
REQ-006 SHALL have parameters K_LEFT 8'h6B, K_RIGHT 8'h74, K_UP 8'h75, K_DOWN 8'h72: PS/2 arrow scan codes.
REQ-007 SHALL have the following ports:
 - clk  in  1  system clock; all state on its rising edge.
 - reset  in  1  asynchronous, active-low reset.
 - enable  in  1  movement enable.
 - load  in  1  strobe: restart the player at start_x/start_y.
 - key_valid  in  1  one-cycle strobe qualifying key_code/key_break.
 - key_code  in  8  scan code.
 - key_break  in  1  1 = release event, 0 = press event.
 - maze_data  in  GRID_W*GRID_H  bit (y*GRID_W+x); 1 = open cell, 0 = wall.
 - maze_width  in  XW+1  active column count.
 - maze_height  in  YW+1  active row count.
 - start_x/start_y  in  XW/YW  start cell.
 - goal_x/goal_y  in  XW/YW  goal cell.
 - curr_x/curr_y  out  XW/YW  player cell, registered.
 - move_done  out  1  one-cycle pulse: a move was taken.
 - bump  out  1  one-cycle pulse: a move was blocked.
 - at_goal  out  1  level: player is at the goal cell.
 - step_count  out  16  moves taken since load.

Function
REQ-008 SHALL keep four held flags (L, R, U, D): set on a press of the matching code, cleared on its release; unknown codes and releases of non-held keys SHALL be ignored.
REQ-009 SHALL implement FSM states IDLE, STEP, WAIT, and FROZEN.
REQ-010 IDLE SHALL go to STEP when any held flag is 1, enable=1, and at_goal=0.
REQ-011 In STEP, when several flags are held, the active direction SHALL be chosen by fixed priority U > D > L > R.
REQ-012 STEP SHALL compute the target cell; the target SHALL be legal only if it lies within 0..eff_w-1 and 0..eff_h-1 (no wrap) and its maze_data bit is 1.
REQ-013 eff_w SHALL be min(maze_width, GRID_W) and eff_h SHALL be min(maze_height, GRID_H).
REQ-014 If the target is legal, STEP SHALL update curr, pulse move_done, and increment step_count, saturating at 16'hFFFF.
REQ-015 If the target is illegal, STEP SHALL leave curr unchanged and pulse bump.
REQ-016 STEP SHALL then go to WAIT, loading the repeat counter with STEP_CYCLES-2.
REQ-017 WAIT SHALL decrement the counter; at 0 it SHALL go to STEP if a flag is still held, otherwise to IDLE; if all flags clear early, it SHALL go to IDLE on the next cycle.
REQ-018 Latency: for a press with key_valid sampled at edge N, curr SHALL update at edge N+2, and each repeat SHALL follow STEP_CYCLES cycles after the previous STEP.
REQ-019 at_goal SHALL equal (curr==goal), registered; when a move lands on the goal, the FSM SHALL enter FROZEN, which ignores keys until load.
REQ-020 load SHALL take priority over all else: curr<=start, step_count<=0, held flags cleared, FSM to IDLE (FROZEN if start==goal).
REQ-021 An off-grid start SHALL be loaded as given, and subsequent moves SHALL still be bounds-checked.
REQ-022 enable=0 SHALL force the FSM to IDLE, clear the held flags, and ignore key events; curr and step_count SHALL be retained.
REQ-023 A press and release of the same key in one strobe is impossible; a release arriving during STEP SHALL still let that STEP complete.

Reset
REQ-024 While reset=0, asynchronously: curr_x=0, curr_y=0, step_count=0, move_done=0, bump=0, at_goal=0, held flags=0, FSM=IDLE, repeat counter=0.
REQ-025 Reset deasserted mid-WAIT SHALL resume from IDLE with no spurious move_done or bump.

Verification
REQ-026 Open 16x16 maze, load start (3,3), press K_RIGHT at edge N -> curr_x=4 at N+2, move_done pulse, step_count=1.
REQ-027 STEP_CYCLES=8, hold K_DOWN from (0,0) for 30 cycles -> curr_y increments at N+2, +10, +18, +26; release -> no further moves.
REQ-028 Wall at (5,3), player at (4,3), press K_RIGHT -> curr unchanged, bump pulse, step_count unchanged.
REQ-029 maze_width=10, player at (9,0), press K_RIGHT -> bump, no wrap; at (0,0), press K_LEFT -> bump.
REQ-030 goal=(6,3), player at (5,3), hold K_RIGHT -> at_goal=1 after one move, no further moves; pulse load -> curr=start, step_count=0, at_goal=0.
REQ-031 Hold K_UP and K_LEFT together -> only y moves; drop enable mid-WAIT -> no move until a new press after enable=1.

Source files
------------

// File: rtl/maze_player_ctrl.sv
// Maze player controller: turns PS/2 arrow key press/release events into
// grid moves with auto-repeat, wall/bounds checking, a goal freeze and a
// saturating move counter.
module maze_player_ctrl #(
   parameter int         GRID_W      = 16,
   parameter int         GRID_H      = 16,
   parameter int         XW          = 4,
   parameter int         YW          = 4,
   parameter int         STEP_CYCLES = 5_000_000,
   parameter logic [7:0] K_LEFT      = 8'h6B,
   parameter logic [7:0] K_RIGHT     = 8'h74,
   parameter logic [7:0] K_UP        = 8'h75,
   parameter logic [7:0] K_DOWN      = 8'h72
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       enable,
   input  logic                       load,
   input  logic                       key_valid,
   input  logic [7:0]                 key_code,
   input  logic                       key_break,
   input  logic [GRID_W*GRID_H-1:0]   maze_data,
   input  logic [XW:0]                maze_width,
   input  logic [YW:0]                maze_height,
   input  logic [XW-1:0]              start_x,
   input  logic [YW-1:0]              start_y,
   input  logic [XW-1:0]              goal_x,
   input  logic [YW-1:0]              goal_y,
   output logic [XW-1:0]              curr_x,
   output logic [YW-1:0]              curr_y,
   output logic                       move_done,
   output logic                       bump,
   output logic                       at_goal,
   output logic [15:0]                step_count
);

   localparam int CELLS = GRID_W * GRID_H;
   localparam int IW    = $clog2(CELLS) + 1;
   localparam int CW    = (STEP_CYCLES > 2) ? $clog2(STEP_CYCLES) : 1;
   localparam logic [CW-1:0] RELOAD = CW'(STEP_CYCLES - 2);

   // Held-flag bit positions.
   localparam int H_L = 0;
   localparam int H_R = 1;
   localparam int H_U = 2;
   localparam int H_D = 3;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_STEP   = 2'd1,
      S_WAIT   = 2'd2,
      S_FROZEN = 2'd3
   } state_e;

   typedef enum logic [1:0] {
      D_UP    = 2'd0,
      D_DOWN  = 2'd1,
      D_LEFT  = 2'd2,
      D_RIGHT = 2'd3
   } dir_e;

   // Fixed direction priority U > D > L > R.
   function automatic dir_e pick_dir(input logic [3:0] held);
      if (held[H_U]) begin
         return D_UP;
      end else if (held[H_D]) begin
         return D_DOWN;
      end else if (held[H_L]) begin
         return D_LEFT;
      end else begin
         return D_RIGHT;
      end
   endfunction

   state_e          state_q, state_d;
   dir_e            dir_q, dir_d;
   logic [3:0]      held_q, held_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [XW-1:0]   curr_x_q, curr_x_d;
   logic [YW-1:0]   curr_y_q, curr_y_d;
   logic [15:0]     step_q, step_d;
   logic            move_q, move_d;
   logic            bump_q, bump_d;
   logic            at_goal_q, at_goal_d;

   logic [XW:0]     tx_s, eff_w_s;
   logic [YW:0]     ty_s, eff_h_s;
   logic            under_s, in_range_s, open_s, legal_s, hit_goal_s, start_is_goal_s;
   logic [IW-1:0]   cell_idx_s;
   logic [CELLS-1:0] cell_mask_s;

   assign eff_w_s = (maze_width  > (XW+1)'(GRID_W)) ? (XW+1)'(GRID_W) : maze_width;
   assign eff_h_s = (maze_height > (YW+1)'(GRID_H)) ? (YW+1)'(GRID_H) : maze_height;

   // Target cell for the latched direction; underflow is flagged instead of wrapping.
   always_comb begin
      tx_s    = {1'b0, curr_x_q};
      ty_s    = {1'b0, curr_y_q};
      under_s = 1'b0;
      case (dir_q)
         D_UP: begin
            if (curr_y_q == {YW{1'b0}}) under_s = 1'b1;
            else                        ty_s = ty_s - (YW+1)'(1);
         end
         D_DOWN:  ty_s = ty_s + (YW+1)'(1);
         D_LEFT: begin
            if (curr_x_q == {XW{1'b0}}) under_s = 1'b1;
            else                        tx_s = tx_s - (XW+1)'(1);
         end
         D_RIGHT: tx_s = tx_s + (XW+1)'(1);
         default: under_s = 1'b1;
      endcase
   end

   assign in_range_s = !under_s && (tx_s < eff_w_s) && (ty_s < eff_h_s);
   assign cell_idx_s = IW'(ty_s) * IW'(GRID_W) + IW'(tx_s);
   assign cell_mask_s = {{(CELLS-1){1'b0}}, 1'b1} << cell_idx_s;
   assign open_s     = |(maze_data & cell_mask_s);
   assign legal_s    = in_range_s && open_s;
   assign hit_goal_s = legal_s && (tx_s[XW-1:0] == goal_x) && (ty_s[YW-1:0] == goal_y);
   assign start_is_goal_s = (start_x == goal_x) && (start_y == goal_y);

   // FSM state register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // FSM next-state logic; load beats enable, enable beats everything else.
   always_comb begin
      state_d = state_q;
      if (load) begin
         state_d = start_is_goal_s ? S_FROZEN : S_IDLE;
      end else if (!enable) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE:   state_d = ((held_q != 4'b0000) && !at_goal_q) ? S_STEP : S_IDLE;
            S_STEP:   state_d = hit_goal_s ? S_FROZEN : S_WAIT;
            S_WAIT: begin
               if (held_q == 4'b0000)   state_d = S_IDLE;
               else if (cnt_q == '0)    state_d = S_STEP;
               else                     state_d = S_WAIT;
            end
            S_FROZEN: state_d = S_FROZEN;
            default:  state_d = S_IDLE;
         endcase
      end
   end

   // FSM outputs and datapath next values: held flags, move/bump, counters.
   always_comb begin
      held_d   = held_q;
      dir_d    = dir_q;
      cnt_d    = cnt_q;
      curr_x_d = curr_x_q;
      curr_y_d = curr_y_q;
      step_d   = step_q;
      move_d   = 1'b0;
      bump_d   = 1'b0;
      if (load) begin
         held_d   = 4'b0000;
         cnt_d    = '0;
         curr_x_d = start_x;
         curr_y_d = start_y;
         step_d   = 16'd0;
      end else begin
         if (!enable || (state_q == S_FROZEN)) begin
            held_d = 4'b0000;
         end else if (key_valid) begin
            case (key_code)
               K_LEFT:  held_d[H_L] = ~key_break;
               K_RIGHT: held_d[H_R] = ~key_break;
               K_UP:    held_d[H_U] = ~key_break;
               K_DOWN:  held_d[H_D] = ~key_break;
               default: held_d = held_q;
            endcase
         end else begin
            held_d = held_q;
         end
         if (enable && (state_q == S_STEP)) begin
            if (legal_s) begin
               curr_x_d = tx_s[XW-1:0];
               curr_y_d = ty_s[YW-1:0];
               move_d   = 1'b1;
               step_d   = (step_q != 16'hFFFF) ? step_q + 16'd1 : step_q;
            end else begin
               bump_d   = 1'b1;
            end
            cnt_d = RELOAD;
         end else if ((state_q == S_WAIT) && (cnt_q != '0)) begin
            cnt_d = cnt_q - CW'(1);
         end else begin
            cnt_d = cnt_q;
         end
         // Direction is latched on entry to STEP so a release during STEP cannot cancel it.
         if (state_d == S_STEP) dir_d = pick_dir(held_q);
         else                   dir_d = dir_q;
      end
      at_goal_d = (curr_x_d == goal_x) && (curr_y_d == goal_y);
   end

   // Datapath and output registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         held_q    <= 4'b0000;
         dir_q     <= D_UP;
         cnt_q     <= '0;
         curr_x_q  <= '0;
         curr_y_q  <= '0;
         step_q    <= 16'd0;
         move_q    <= 1'b0;
         bump_q    <= 1'b0;
         at_goal_q <= 1'b0;
      end else begin
         held_q    <= held_d;
         dir_q     <= dir_d;
         cnt_q     <= cnt_d;
         curr_x_q  <= curr_x_d;
         curr_y_q  <= curr_y_d;
         step_q    <= step_d;
         move_q    <= move_d;
         bump_q    <= bump_d;
         at_goal_q <= at_goal_d;
      end
   end

   assign curr_x     = curr_x_q;
   assign curr_y     = curr_y_q;
   assign move_done  = move_q;
   assign bump       = bump_q;
   assign at_goal    = at_goal_q;
   assign step_count = step_q;

endmodule

// File: tb/tb_maze_player_ctrl.sv
// Directed bench for maze_player_ctrl with STEP_CYCLES=8 on a 16x16 grid.
module tb_maze_player_ctrl;

   localparam int GW = 16;
   localparam int GH = 16;
   localparam int XW = 4;
   localparam int YW = 4;
   localparam int SC = 8;
   localparam logic [7:0] KL = 8'h6B;
   localparam logic [7:0] KR = 8'h74;
   localparam logic [7:0] KU = 8'h75;
   localparam logic [7:0] KD = 8'h72;

   logic              clk = 1'b0;
   logic              reset;
   logic              enable;
   logic              load;
   logic              key_valid;
   logic [7:0]        key_code;
   logic              key_break;
   logic [GW*GH-1:0]  maze_data;
   logic [XW:0]       maze_width;
   logic [YW:0]       maze_height;
   logic [XW-1:0]     start_x, goal_x, curr_x;
   logic [YW-1:0]     start_y, goal_y, curr_y;
   logic              move_done, bump, at_goal;
   logic [15:0]       step_count;

   int n_tests = 0;
   int n_fail  = 0;
   logic seen_pulse;

   maze_player_ctrl #(
      .GRID_W(GW), .GRID_H(GH), .XW(XW), .YW(YW), .STEP_CYCLES(SC),
      .K_LEFT(KL), .K_RIGHT(KR), .K_UP(KU), .K_DOWN(KD)
   ) dut (
      .clk(clk), .reset(reset), .enable(enable), .load(load),
      .key_valid(key_valid), .key_code(key_code), .key_break(key_break),
      .maze_data(maze_data), .maze_width(maze_width), .maze_height(maze_height),
      .start_x(start_x), .start_y(start_y), .goal_x(goal_x), .goal_y(goal_y),
      .curr_x(curr_x), .curr_y(curr_y), .move_done(move_done), .bump(bump),
      .at_goal(at_goal), .step_count(step_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   // One key event strobe; the edge it is sampled on is the edge this task returns after.
   task automatic key(input logic [7:0] code, input logic brk);
      key_code  = code;
      key_break = brk;
      key_valid = 1'b1;
      tick();
      key_valid = 1'b0;
   endtask

   task automatic do_load(input logic [XW-1:0] sx, input logic [YW-1:0] sy);
      start_x = sx;
      start_y = sy;
      load    = 1'b1;
      tick();
      load    = 1'b0;
   endtask

   initial begin
      reset = 1'b0; enable = 1'b1; load = 1'b0;
      key_valid = 1'b0; key_code = 8'h00; key_break = 1'b0;
      maze_data = '1; maze_width = 5'd16; maze_height = 5'd16;
      start_x = 4'd0; start_y = 4'd0; goal_x = 4'd15; goal_y = 4'd15;
      ticks(2);
      chk("rst_x", curr_x, 0);
      chk("rst_y", curr_y, 0);
      chk("rst_step", step_count, 0);
      chk("rst_md", move_done, 0);
      chk("rst_bump", bump, 0);
      chk("rst_goal", at_goal, 0);
      reset = 1'b1;
      tick();

      // Single press from (3,3): move lands two edges after the strobe.
      do_load(4'd3, 4'd3);
      chk("load_x", curr_x, 3);
      chk("load_step", step_count, 0);
      key(KR, 1'b0);
      tick();
      chk("lat_n1_x", curr_x, 3);
      tick();
      chk("lat_n2_x", curr_x, 4);
      chk("lat_n2_y", curr_y, 3);
      chk("lat_n2_md", move_done, 1);
      chk("lat_n2_step", step_count, 1);
      key(KR, 1'b1);
      chk("md_pulse_end", move_done, 0);
      ticks(10);
      chk("single_x", curr_x, 4);
      chk("single_step", step_count, 1);

      // Held DOWN auto-repeats every 8 cycles.
      do_load(4'd0, 4'd0);
      key(KD, 1'b0);
      for (int k = 1; k < 30; k++) begin
         tick();
         if (k == 2)  chk("rep_n2",  curr_y, 1);
         if (k == 9)  chk("rep_n9",  curr_y, 1);
         if (k == 10) chk("rep_n10", curr_y, 2);
         if (k == 10) chk("rep_md10", move_done, 1);
         if (k == 11) chk("rep_md11", move_done, 0);
         if (k == 18) chk("rep_n18", curr_y, 3);
         if (k == 26) chk("rep_n26", curr_y, 4);
      end
      key(KD, 1'b1);
      ticks(12);
      chk("rep_stop_y", curr_y, 4);
      chk("rep_stop_step", step_count, 4);

      // Wall at (5,3).
      maze_data[3*GW+5] = 1'b0;
      do_load(4'd4, 4'd3);
      key(KR, 1'b0);
      ticks(2);
      chk("wall_x", curr_x, 4);
      chk("wall_bump", bump, 1);
      chk("wall_md", move_done, 0);
      chk("wall_step", step_count, 0);
      key(KR, 1'b1);
      chk("wall_bump_end", bump, 0);
      ticks(3);
      maze_data = '1;

      // Active width 10: 8->9 legal, repeat at 9 bumps.
      maze_width = 5'd10;
      do_load(4'd8, 4'd0);
      key(KR, 1'b0);
      ticks(2);
      chk("w10_move_x", curr_x, 9);
      ticks(8);
      chk("w10_bump", bump, 1);
      chk("w10_nowrap_x", curr_x, 9);
      key(KR, 1'b1);
      ticks(3);
      do_load(4'd0, 4'd0);
      key(KL, 1'b0);
      ticks(2);
      chk("left0_bump", bump, 1);
      chk("left0_x", curr_x, 0);
      key(KL, 1'b1);
      ticks(3);
      // Width above grid size clamps to 16.
      maze_width = 5'd31;
      do_load(4'd15, 4'd0);
      key(KR, 1'b0);
      ticks(2);
      chk("clamp_bump", bump, 1);
      chk("clamp_x", curr_x, 15);
      key(KR, 1'b1);
      ticks(3);
      maze_width = 5'd16;

      // Goal freeze.
      goal_x = 4'd6; goal_y = 4'd3;
      do_load(4'd5, 4'd3);
      chk("goal_pre", at_goal, 0);
      key(KR, 1'b0);
      ticks(2);
      chk("goal_x", curr_x, 6);
      chk("goal_flag", at_goal, 1);
      chk("goal_step", step_count, 1);
      ticks(20);
      chk("frozen_x", curr_x, 6);
      chk("frozen_step", step_count, 1);
      key(KR, 1'b1);
      do_load(4'd2, 4'd2);
      chk("reload_x", curr_x, 2);
      chk("reload_y", curr_y, 2);
      chk("reload_step", step_count, 0);
      chk("reload_goal", at_goal, 0);
      do_load(4'd6, 4'd3);
      chk("start_goal", at_goal, 1);
      key(KL, 1'b0);
      ticks(4);
      chk("start_goal_x", curr_x, 6);
      key(KL, 1'b1);
      goal_x = 4'd15; goal_y = 4'd15;
      do_load(4'd0, 4'd0);

      // UP+LEFT held: only y moves; enable drop clears held keys.
      do_load(4'd5, 4'd5);
      key(KU, 1'b0);
      key(KL, 1'b0);
      tick();
      chk("ul_y1", curr_y, 4);
      chk("ul_x1", curr_x, 5);
      ticks(8);
      chk("ul_y2", curr_y, 3);
      chk("ul_x2", curr_x, 5);
      ticks(3);
      enable = 1'b0;
      tick();
      enable = 1'b1;
      ticks(20);
      chk("en_y", curr_y, 3);
      chk("en_x", curr_x, 5);
      chk("en_step", step_count, 2);
      key(KD, 1'b0);
      ticks(2);
      chk("en_repress_y", curr_y, 4);
      key(KD, 1'b1);
      ticks(3);

      // Reset in the middle of WAIT.
      do_load(4'd3, 4'd3);
      key(KR, 1'b0);
      ticks(4);
      reset = 1'b0;
      #1;
      chk("async_rst_x", curr_x, 0);
      chk("async_rst_step", step_count, 0);
      tick();
      reset = 1'b1;
      seen_pulse = 1'b0;
      for (int k = 0; k < 12; k++) begin
         tick();
         if (move_done || bump) seen_pulse = 1'b1;
      end
      chk("post_rst_pulse", seen_pulse, 0);
      chk("post_rst_x", curr_x, 0);
      key(KR, 1'b1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
